// File: rtl/seq_engine.sv
// seq_engine: programmable-rate sequence generator with three modes
// (Fibonacci, up-count timer, down-count from preset). A prescaler
// paces the steps; value/tick/done/ovf are registered outputs and the
// state register is one-hot so led is driven straight from it.
module seq_engine #(
  parameter int WIDTH    = 16,
  parameter int PROG_W   = 3,
  parameter int DIV_BASE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_f,
  input  logic              start_t,
  input  logic              start_d,
  input  logic              stop_f_t,
  input  logic              update,
  input  logic [PROG_W-1:0] prog,
  input  logic [WIDTH-1:0]  preset,
  output logic [WIDTH-1:0]  value,
  output logic              tick,
  output logic              done,
  output logic              ovf,
  output logic [3:0]        led
);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_FIB  = 4'b0010,
    S_UP   = 4'b0100,
    S_DOWN = 4'b1000
  } state_t;

  localparam logic [WIDTH-1:0] VMAX = '1;
  localparam logic [WIDTH-1:0] VONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t             state_reg;
  logic [WIDTH-1:0]   value_reg;
  logic [WIDTH:0]     fib_next_reg;   // one bit wider so a pending overflow is visible
  logic [PROG_W-1:0]  rate_reg;
  logic [31:0]        pre_reg;
  logic               tick_reg;
  logic               done_reg;
  logic               ovf_reg;

  logic [31:0]        period_m1;
  logic               start_acc;
  logic               step_due;

  // Last prescaler count of a step period: P-1 with P = (rate+1)*DIV_BASE.
  assign period_m1 = (32'(rate_reg) + 32'd1) * 32'(DIV_BASE) - 32'd1;

  // Start acceptance (IDLE only, stop wins) and step timing; an update
  // restarts the period, so it also cancels a step due in that cycle.
  always_comb begin
    start_acc = (state_reg == S_IDLE) && !stop_f_t && (start_f || start_t || start_d);
    step_due  = (state_reg != S_IDLE) && !update && (pre_reg == period_m1);
  end

  // Rate register and prescaler: cleared by update and by an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rate_reg <= '0;
      pre_reg  <= '0;
    end else begin
      if (update) rate_reg <= prog;
      if (update || start_acc)
        pre_reg <= '0;
      else if (state_reg != S_IDLE)
        pre_reg <= step_due ? 32'd0 : pre_reg + 32'd1;
    end
  end

  // Sequencer FSM with registered value, tick, done and sticky ovf.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      value_reg    <= '0;
      fib_next_reg <= {{WIDTH{1'b0}}, 1'b1};
      tick_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      done_reg <= 1'b0;
      if (state_reg == S_IDLE) begin
        if (start_acc) begin
          ovf_reg <= 1'b0;
          if (start_f) begin
            state_reg    <= S_FIB;
            value_reg    <= '0;
            fib_next_reg <= {{WIDTH{1'b0}}, 1'b1};
          end else if (start_t) begin
            state_reg <= S_UP;
            value_reg <= '0;
          end else begin
            state_reg <= S_DOWN;
            value_reg <= preset;
          end
        end
      end else if (stop_f_t) begin
        state_reg <= S_IDLE;
      end else if ((state_reg == S_DOWN) && (value_reg == '0)) begin
        // Only reachable from a zero preset: terminate without a step.
        done_reg  <= 1'b1;
        state_reg <= S_IDLE;
      end else if (step_due) begin
        case (state_reg)
          S_FIB: begin
            if (fib_next_reg > {1'b0, VMAX}) begin
              ovf_reg   <= 1'b1;
              done_reg  <= 1'b1;
              state_reg <= S_IDLE;
            end else begin
              value_reg    <= fib_next_reg[WIDTH-1:0];
              fib_next_reg <= {1'b0, value_reg} + fib_next_reg;
              tick_reg     <= 1'b1;
            end
          end
          S_UP: begin
            if (value_reg == VMAX) begin
              ovf_reg   <= 1'b1;
              done_reg  <= 1'b1;
              state_reg <= S_IDLE;
            end else begin
              value_reg <= value_reg + VONE;
              tick_reg  <= 1'b1;
            end
          end
          S_DOWN: begin
            value_reg <= value_reg - VONE;
            tick_reg  <= 1'b1;
            if (value_reg == VONE) begin
              done_reg  <= 1'b1;
              state_reg <= S_IDLE;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign value = value_reg;
  assign tick  = tick_reg;
  assign done  = done_reg;
  assign ovf   = ovf_reg;
  assign led   = state_reg;

endmodule
